nebula_packet_reassembler: RTL
==============================

# nebula_packet_reassembler

Receive-side counterpart of the network-interface packetizer. Accepts 256-bit `noc_flit_t` flits from a router's PORT_LOCAL output, checks the framing (HEAD/BODY/TAIL/SINGLE), and rebuilds each packet into one wide payload word plus header fields. Returns one credit per consumed flit and reports framing and addressing errors using `error_code_e` values. Sits between the router local port and the AXI/CHI protocol bridges.

## Interface
- `LOCAL_X`, default 0: x coordinate of this node, compared against `dest_x`.
- `LOCAL_Y`, default 0: y coordinate of this node, compared against `dest_y`.
- `MAX_FLITS`, default 8 (FLITS_PER_PACKET): maximum flits per packet.
- `PAYLOAD_W`, default 208 (PAYLOAD_BITS_PER_FLIT): payload bits per flit.
- `clk`  in  1  sole clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `flit_in`  in  256  flit, laid out as `noc_flit_t`. Bit fields:
  - [255:254] type; [253:252] vc; [251:248] dest_x; [247:244] dest_y
  - [243:240] src_x; [239:236] src_y; [235:220] seq; [219:212] pkt_id
  - [211:208] qos; [207:0] payload
- `flit_valid`  in  1  flit present.
- `flit_ready`  out  1  reassembler can accept a flit.
- `pkt_valid`  out  1  reassembled packet available.
- `pkt_ready`  in  1  downstream accepts the packet.
- `pkt_data`  out  MAX_FLITS*PAYLOAD_W  flit k payload at [k*PAYLOAD_W +: PAYLOAD_W]; unused slots are zero.
- `pkt_len`  out  4  number of flits, 1..MAX_FLITS.
- `pkt_src_x`, `pkt_src_y`  out  4 each  source coordinates from the head flit.
- `pkt_id`  out  8  packet_id from the head flit.
- `pkt_seq`  out  16  seq_num from the head flit.
- `pkt_qos`  out  4  qos from the head flit.
- `pkt_vc`  out  2  vc_id from the head flit.
- `credit_valid`  out  1  one-cycle credit-return pulse.
- `credit_vc`  out  2  VC being credited.
- `err_valid`  out  1  one-cycle error pulse.
- `err_code`  out  8  ERR_PROTOCOL 0x06, ERR_BUFFER_OVERFLOW 0x03, ERR_INVALID_DEST 0x04.

## Operation
- A flit is accepted when `flit_valid && flit_ready`.
- States: IDLE, COLLECT, DELIVER, DISCARD. `flit_ready` = 1 in every state except DELIVER.
- IDLE:
  - HEAD with matching dest: latch header fields, store payload in slot 0, count=1 -> COLLECT.
  - SINGLE with matching dest: same capture, count=1 -> DELIVER.
  - HEAD or SINGLE with dest != (LOCAL_X, LOCAL_Y): error 0x04. HEAD -> DISCARD; SINGLE stays IDLE.
  - BODY or TAIL: drop, error 0x06, stay IDLE.
- COLLECT:
  - BODY or TAIL with pkt_id equal to the latched id and count<MAX_FLITS: store in slot count, count++. BODY stays COLLECT; TAIL -> DELIVER.
  - Same-id flit with count==MAX_FLITS: error 0x03, packet dropped. BODY -> DISCARD; TAIL -> IDLE.
  - pkt_id mismatch: error 0x06, packet dropped. BODY -> DISCARD; TAIL -> IDLE.
  - HEAD or SINGLE: error 0x06. Abandon the current packet, clear the data buffer, then handle the new flit exactly as in IDLE.
- DELIVER: `pkt_valid`=1 with all `pkt_*` outputs stable until `pkt_ready`. On handshake: clear the buffer, -> IDLE.
- DISCARD (silent, no error pulses):
  - BODY: drop.
  - TAIL: -> IDLE.
  - HEAD or SINGLE: handled as in IDLE.
- Every accepted flit, including dropped ones, returns a credit: `credit_valid`=1 on the next cycle, with `credit_vc` = that flit's vc field.
- `pkt_len` is count in 4 bits; it never exceeds MAX_FLITS.

## Timing
- Reset (`rst`=1 at a clock edge):
  - State=IDLE, count=0, `pkt_data`=0.
  - `pkt_valid`=0, `credit_valid`=0, `err_valid`=0, `err_code`=0x00, all `pkt_*` fields=0.
  - `flit_ready`=1 from the first cycle after reset.
  - Reset in the middle of a packet discards it; no credit or error is issued for the partial packet.
- Latency: a TAIL or SINGLE accepted in cycle N gives `pkt_valid`=1 in cycle N+1.
- The packet handshake in cycle M gives `flit_ready`=1 in cycle M+1. No same-cycle bypass.
- `err_valid` and `credit_valid` are registered. Both assert in the cycle after the offending or consumed flit, for exactly one cycle.
- Back-to-back flits are accepted every cycle in IDLE, COLLECT and DISCARD.
- A HEAD arriving in COLLECT causes one error pulse and one credit, both in the next cycle.

## Test plan
- SINGLE flit, dest=(0,0), payload=0xABCD, pkt_id=0x11 -> next cycle `pkt_valid`=1, `pkt_len`=1, `pkt_data[207:0]`=0xABCD, `credit_valid`=1.
- HEAD+BODY+BODY+TAIL with payloads 1..4, `pkt_ready` held low 5 cycles:
  - `pkt_len`=4, slot k holds k+1.
  - `flit_ready`=0 while `pkt_valid`=1.
  - Exactly 4 credits issued.
- HEAD followed by 8 BODY flits -> `err_code`=0x03 after the 8th BODY, then silent discard through the TAIL, no `pkt_valid`, 10 credits total.
- TAIL while IDLE -> `err_code`=0x06, one credit, state stays IDLE. A following SINGLE is delivered normally.
- HEAD with dest=(2,1) at LOCAL=(0,0) -> `err_code`=0x04, its BODY and TAIL dropped without further errors.
- Reset asserted after the 2nd flit of a 4-flit packet -> all outputs zero. A new SINGLE is then delivered with `pkt_len`=1 and slots 1..7 zero.

Source files
------------

// File: rtl/nebula_packet_reassembler_if.sv
// Router local-port flit input, reassembled packet output, credit return and error reporting.
interface nebula_packet_reassembler_if #(
  parameter int unsigned MAX_FLITS = 8,
  parameter int unsigned PAYLOAD_W = 208
);
  logic [255:0]                     flit_in;
  logic                             flit_valid;
  logic                             flit_ready;
  logic                             pkt_valid;
  logic                             pkt_ready;
  logic [MAX_FLITS*PAYLOAD_W-1:0]   pkt_data;
  logic [3:0]                       pkt_len;
  logic [3:0]                       pkt_src_x;
  logic [3:0]                       pkt_src_y;
  logic [7:0]                       pkt_id;
  logic [15:0]                      pkt_seq;
  logic [3:0]                       pkt_qos;
  logic [1:0]                       pkt_vc;
  logic                             credit_valid;
  logic [1:0]                       credit_vc;
  logic                             err_valid;
  logic [7:0]                       err_code;

  modport slave (
    input  flit_in, flit_valid, pkt_ready,
    output flit_ready, pkt_valid, pkt_data, pkt_len, pkt_src_x, pkt_src_y,
           pkt_id, pkt_seq, pkt_qos, pkt_vc, credit_valid, credit_vc,
           err_valid, err_code
  );

  modport master (
    output flit_in, flit_valid, pkt_ready,
    input  flit_ready, pkt_valid, pkt_data, pkt_len, pkt_src_x, pkt_src_y,
           pkt_id, pkt_seq, pkt_qos, pkt_vc, credit_valid, credit_vc,
           err_valid, err_code
  );
endinterface

// File: rtl/nebula_packet_reassembler.sv
// Rebuilds HEAD/BODY/TAIL/SINGLE flit streams into one wide packet word, returning
// a credit per consumed flit and flagging framing and addressing errors.
module nebula_packet_reassembler #(
  parameter int unsigned LOCAL_X   = 0,
  parameter int unsigned LOCAL_Y   = 0,
  parameter int unsigned MAX_FLITS = 8,
  parameter int unsigned PAYLOAD_W = 208
) (
  input logic                     clk,
  input logic                     rst,
  nebula_packet_reassembler_if.slave bus
);

  localparam int unsigned LEN_W = 4;
  localparam int unsigned IDX_W = (MAX_FLITS > 1) ? $clog2(MAX_FLITS) : 1;

  localparam logic [7:0] ERR_PROTOCOL        = 8'h06;
  localparam logic [7:0] ERR_BUFFER_OVERFLOW = 8'h03;
  localparam logic [7:0] ERR_INVALID_DEST    = 8'h04;

  typedef enum logic [1:0] {
    FT_HEAD   = 2'd0,
    FT_BODY   = 2'd1,
    FT_TAIL   = 2'd2,
    FT_SINGLE = 2'd3
  } flit_type_e;

  typedef struct packed {
    flit_type_e   ftype;
    logic [1:0]   vc;
    logic [3:0]   dest_x;
    logic [3:0]   dest_y;
    logic [3:0]   src_x;
    logic [3:0]   src_y;
    logic [15:0]  seq;
    logic [7:0]   pkt_id;
    logic [3:0]   qos;
    logic [207:0] payload;
  } noc_flit_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DELIVER = 2'd2,
    DISCARD = 2'd3
  } state_e;

  state_e                             state;
  state_e                             start_state;
  logic [LEN_W-1:0]                   count;
  logic [MAX_FLITS-1:0][PAYLOAD_W-1:0] slots;

  noc_flit_t            flit;
  logic                 accept;
  logic                 is_head;
  logic                 is_start;
  logic                 is_tail;
  logic                 dest_ok;
  logic                 id_ok;
  logic                 full;
  logic [PAYLOAD_W-1:0] payload;

  assign flit     = noc_flit_t'(bus.flit_in);
  assign accept   = bus.flit_valid && bus.flit_ready;
  assign is_head  = (flit.ftype == FT_HEAD);
  assign is_tail  = (flit.ftype == FT_TAIL);
  assign is_start = is_head || (flit.ftype == FT_SINGLE);
  assign dest_ok  = (flit.dest_x == 4'(LOCAL_X)) && (flit.dest_y == 4'(LOCAL_Y));
  assign id_ok    = (flit.pkt_id == bus.pkt_id);
  assign full     = (count == LEN_W'(MAX_FLITS));
  assign payload  = PAYLOAD_W'(flit.payload);

  assign bus.pkt_data = slots;
  assign bus.pkt_len  = count;

  // Where a HEAD/SINGLE leads, identical from IDLE, COLLECT and DISCARD
  always_comb begin
    start_state = IDLE;
    if (!dest_ok) start_state = is_head ? DISCARD : IDLE;
    else          start_state = is_head ? COLLECT : DELIVER;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      count            <= '0;
      slots            <= '0;
      bus.flit_ready   <= 1'b1;
      bus.pkt_valid    <= 1'b0;
      bus.pkt_src_x    <= '0;
      bus.pkt_src_y    <= '0;
      bus.pkt_id       <= '0;
      bus.pkt_seq      <= '0;
      bus.pkt_qos      <= '0;
      bus.pkt_vc       <= '0;
      bus.credit_valid <= 1'b0;
      bus.credit_vc    <= '0;
      bus.err_valid    <= 1'b0;
      bus.err_code     <= '0;
    end else begin
      bus.credit_valid <= accept;
      if (accept) bus.credit_vc <= flit.vc;
      bus.err_valid <= 1'b0;

      case (state)
        DELIVER: begin
          if (bus.pkt_ready) begin
            slots          <= '0;
            count          <= '0;
            bus.pkt_valid  <= 1'b0;
            bus.flit_ready <= 1'b1;
            state          <= IDLE;
          end
        end
        default: begin
          if (accept) begin
            if (is_start) begin
              // A new packet always starts from a clean buffer
              slots <= '0;
              state <= start_state;
              if (dest_ok) begin
                slots[0]      <= payload;
                count         <= LEN_W'(1);
                bus.pkt_src_x <= flit.src_x;
                bus.pkt_src_y <= flit.src_y;
                bus.pkt_id    <= flit.pkt_id;
                bus.pkt_seq   <= flit.seq;
                bus.pkt_qos   <= flit.qos;
                bus.pkt_vc    <= flit.vc;
              end else begin
                count         <= '0;
                bus.err_valid <= 1'b1;
                bus.err_code  <= ERR_INVALID_DEST;
              end
              if (start_state == DELIVER) begin
                bus.pkt_valid  <= 1'b1;
                bus.flit_ready <= 1'b0;
              end
              // Truncated packet outranks any addressing fault on the new head
              if (state == COLLECT) begin
                bus.err_valid <= 1'b1;
                bus.err_code  <= ERR_PROTOCOL;
              end
            end else if (state == COLLECT) begin
              if (!id_ok || full) begin
                bus.err_valid <= 1'b1;
                bus.err_code  <= id_ok ? ERR_BUFFER_OVERFLOW : ERR_PROTOCOL;
                slots         <= '0;
                count         <= '0;
                state         <= is_tail ? IDLE : DISCARD;
              end else begin
                slots[IDX_W'(count)] <= payload;
                count                <= count + LEN_W'(1);
                if (is_tail) begin
                  bus.pkt_valid  <= 1'b1;
                  bus.flit_ready <= 1'b0;
                  state          <= DELIVER;
                end
              end
            end else if (state == IDLE) begin
              bus.err_valid <= 1'b1;
              bus.err_code  <= ERR_PROTOCOL;
            end else if (is_tail) begin
              state <= IDLE;
            end
          end
        end
      endcase
    end
  end

endmodule
